// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared constants and types for the ID-stage branch hazard controller:
// FSM state encodings, hazard stall counts and the pipeline control bundle.
package branch_hazard_ctrl_pkg;

   localparam int REG_W_DEF = 5;
   localparam int CNT_W_DEF = 16;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_STALL   = 2'd1;
   localparam logic [1:0] ST_RESOLVE = 2'd2;

   localparam logic [1:0] HAZ_NONE = 2'd0;
   localparam logic [1:0] HAZ_ONE  = 2'd1;
   localparam logic [1:0] HAZ_TWO  = 2'd2;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic idex_bubble;
      logic ifid_flush;
      logic branch_taken;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0,
                                       ifid_flush: 1'b0, branch_taken: 1'b0};
   localparam pipe_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1,
                                         ifid_flush: 1'b0, branch_taken: 1'b0};

   function automatic logic branch_is_taken(input logic beq, input logic bne, input logic zero);
      return (beq & zero) | (bne & ~zero);
   endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the branch hazard controller.
// The pipeline drives through master; the controller sits on slave.
interface branch_hazard_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic             id_branch;
   logic             id_branch_not;
   logic             id_zero;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             ex_regwrite;
   logic             ex_memread;
   logic [REG_W-1:0] ex_rd;
   logic             mem_regwrite;
   logic             mem_memread;
   logic [REG_W-1:0] mem_rd;

   logic             pc_write;
   logic             ifid_write;
   logic             idex_bubble;
   logic             ifid_flush;
   logic             branch_taken;
   logic             fwd_a;
   logic             fwd_b;
   logic             branch_err;
   logic [CNT_W-1:0] taken_cnt;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_branch, id_branch_not, id_zero, id_rs, id_rt,
             ex_regwrite, ex_memread, ex_rd, mem_regwrite, mem_memread, mem_rd,
      input  pc_write, ifid_write, idex_bubble, ifid_flush, branch_taken,
             fwd_a, fwd_b, branch_err, taken_cnt, stall_cnt
   );

   modport slave (
      input  id_branch, id_branch_not, id_zero, id_rs, id_rt,
             ex_regwrite, ex_memread, ex_rd, mem_regwrite, mem_memread, mem_rd,
      output pc_write, ifid_write, idex_bubble, ifid_flush, branch_taken,
             fwd_a, fwd_b, branch_err, taken_cnt, stall_cnt
   );

endinterface

// File: rtl/branch_hazard_ctrl_detect.sv
// Combinational operand-hazard check for an ID-stage branch: how many stall
// cycles the comparator needs, and which operands can forward from EX/MEM.
module branch_hazard_detect
   import branch_hazard_ctrl_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) (
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             ex_regwrite_i,
   input  logic             ex_memread_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             mem_regwrite_i,
   input  logic             mem_memread_i,
   input  logic [REG_W-1:0] mem_rd_i,
   output logic [1:0]       hazard_n_o,
   output logic             fwd_a_o,
   output logic             fwd_b_o
);

   logic ex_match;
   logic mem_match;

   // $zero never carries a real dependency, so it can't trigger a hazard.
   assign ex_match  = (ex_rd_i  != '0) && ((ex_rd_i  == id_rs_i) || (ex_rd_i  == id_rt_i));
   assign mem_match = (mem_rd_i != '0) && ((mem_rd_i == id_rs_i) || (mem_rd_i == id_rt_i));

   always_comb begin
      hazard_n_o = HAZ_NONE;
      if (ex_regwrite_i && ex_memread_i && ex_match) begin
         hazard_n_o = HAZ_TWO;
      end else if (ex_regwrite_i && ex_match) begin
         hazard_n_o = HAZ_ONE;
      end else if (mem_memread_i && mem_match) begin
         hazard_n_o = HAZ_ONE;
      end
   end

   assign fwd_a_o = mem_regwrite_i && !mem_memread_i && (mem_rd_i != '0) && (mem_rd_i == id_rs_i);
   assign fwd_b_o = mem_regwrite_i && !mem_memread_i && (mem_rd_i != '0) && (mem_rd_i == id_rt_i);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Sequences beq/bne resolution in ID: stalls for operand hazards, then issues
// taken/not-taken with IF/ID flush; keeps a sticky error flag and perf counters.
module branch_hazard_ctrl
   import branch_hazard_ctrl_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic                clk,
   input logic                rst_n,
   branch_hazard_ctrl_if.slave bus
);

   logic [1:0]       state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic       br;
   logic       taken;
   logic       do_stall;
   logic       do_resolve;
   logic [1:0] hazard_n;
   logic       fwd_a_raw;
   logic       fwd_b_raw;
   pipe_ctrl_t ctrl;

   branch_hazard_detect #(.REG_W(REG_W)) u_detect (
      .id_rs_i        (bus.id_rs),
      .id_rt_i        (bus.id_rt),
      .ex_regwrite_i  (bus.ex_regwrite),
      .ex_memread_i   (bus.ex_memread),
      .ex_rd_i        (bus.ex_rd),
      .mem_regwrite_i (bus.mem_regwrite),
      .mem_memread_i  (bus.mem_memread),
      .mem_rd_i       (bus.mem_rd),
      .hazard_n_o     (hazard_n),
      .fwd_a_o        (fwd_a_raw),
      .fwd_b_o        (fwd_b_raw)
   );

   assign br    = bus.id_branch ^ bus.id_branch_not;
   assign taken = branch_is_taken(bus.id_branch, bus.id_branch_not, bus.id_zero);

   // cnt holds the stall cycles still owed after the current one, so a branch
   // with N hazards sees exactly N stall cycles and then one resolve cycle.
   // Held in reset, nothing stalls or resolves so the pipeline free-runs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      do_stall   = 1'b0;
      do_resolve = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (br) begin
               if (hazard_n != HAZ_NONE) begin
                  do_stall = 1'b1;
                  cnt_d    = hazard_n - 2'd1;
                  state_d  = (hazard_n == HAZ_ONE) ? ST_RESOLVE : ST_STALL;
               end else begin
                  do_resolve = 1'b1;
               end
            end
         end
         ST_STALL: begin
            do_stall = 1'b1;
            cnt_d    = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
            state_d  = (cnt_q <= 2'd1) ? ST_RESOLVE : ST_STALL;
         end
         ST_RESOLVE: begin
            do_resolve = br;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
         end
      endcase
      if (!rst_n) begin
         do_stall   = 1'b0;
         do_resolve = 1'b0;
      end
   end

   always_comb begin
      ctrl = CTRL_RUN;
      if (do_stall) begin
         ctrl = CTRL_STALL;
      end else if (do_resolve && taken) begin
         ctrl.ifid_flush   = 1'b1;
         ctrl.branch_taken = 1'b1;
      end
   end

   // Counters stop at all-ones rather than wrapping.
   always_comb begin
      err_d       = err_q | (bus.id_branch & bus.id_branch_not);
      taken_cnt_d = taken_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (do_resolve && taken && (taken_cnt_q != {CNT_W{1'b1}})) begin
         taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end
      if (do_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 2'd0;
         err_q       <= 1'b0;
         taken_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         taken_cnt_q <= taken_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.pc_write     = ctrl.pc_write;
   assign bus.ifid_write   = ctrl.ifid_write;
   assign bus.idex_bubble  = ctrl.idex_bubble;
   assign bus.ifid_flush   = ctrl.ifid_flush;
   assign bus.branch_taken = ctrl.branch_taken;
   assign bus.fwd_a        = fwd_a_raw & rst_n;
   assign bus.fwd_b        = fwd_b_raw & rst_n;
   assign bus.branch_err   = err_q;
   assign bus.taken_cnt    = taken_cnt_q;
   assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed and randomized checks of the branch hazard controller against a
// cycle-level model that tracks each branch as "stall cycles left, then resolve".
module tb_branch_hazard_ctrl;

   localparam int REG_W = 5;
   localparam int CNT_W = 8;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   branch_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

   branch_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   int mdlActive;
   int mdlRemaining;
   int mdlTaken;
   int mdlStall;
   int mdlErr;
   int pendStartN;
   bit pendStall;
   bit pendTaken;
   bit pendBoth;

   task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      mdlActive    = 0;
      mdlRemaining = 0;
      mdlTaken     = 0;
      mdlStall     = 0;
      mdlErr       = 0;
   endtask

   task automatic clearInputs();
      bus.id_branch     = 1'b0;
      bus.id_branch_not = 1'b0;
      bus.id_zero       = 1'b0;
      bus.id_rs         = '0;
      bus.id_rt         = '0;
      bus.ex_regwrite   = 1'b0;
      bus.ex_memread    = 1'b0;
      bus.ex_rd         = '0;
      bus.mem_regwrite  = 1'b0;
      bus.mem_memread   = 1'b0;
      bus.mem_rd        = '0;
   endtask

   // Stall cycles a branch in ID needs, straight from the producer/consumer rules.
   function automatic int hazardCount();
      int rs, rt, exRd, memRd;
      bit exHit, memHit;
      rs     = int'(bus.id_rs);
      rt     = int'(bus.id_rt);
      exRd   = int'(bus.ex_rd);
      memRd  = int'(bus.mem_rd);
      exHit  = (exRd != 0) && (exRd == rs || exRd == rt);
      memHit = (memRd != 0) && (memRd == rs || memRd == rt);
      if (bus.ex_regwrite && bus.ex_memread && exHit) return 2;
      if (bus.ex_regwrite && exHit) return 1;
      if (bus.mem_memread && memHit) return 1;
      return 0;
   endfunction

   task automatic applyStimulus(input logic b, input logic bn, input logic z, input int rs, input int rt,
                                input logic exRw, input logic exMr, input int exRd,
                                input logic memRw, input logic memMr, input int memRd);
      @(negedge clk);
      bus.id_branch     = b;
      bus.id_branch_not = bn;
      bus.id_zero       = z;
      bus.id_rs         = REG_W'(rs);
      bus.id_rt         = REG_W'(rt);
      bus.ex_regwrite   = exRw;
      bus.ex_memread    = exMr;
      bus.ex_rd         = REG_W'(exRd);
      bus.mem_regwrite  = memRw;
      bus.mem_memread   = memMr;
      bus.mem_rd        = REG_W'(memRd);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      int n;
      bit br, stall, resolve, tk, fa, fb;
      br      = bus.id_branch ^ bus.id_branch_not;
      n       = hazardCount();
      stall   = 1'b0;
      resolve = 1'b0;
      if (mdlActive == 0) begin
         if (br) begin
            if (n > 0) stall = 1'b1;
            else resolve = 1'b1;
         end
      end else if (mdlRemaining > 0) begin
         stall = 1'b1;
      end else begin
         resolve = br;
      end
      tk = resolve && ((bus.id_branch && bus.id_zero) || (bus.id_branch_not && !bus.id_zero));
      fa = bus.mem_regwrite && !bus.mem_memread && bus.mem_rd != 0 && bus.mem_rd == bus.id_rs;
      fb = bus.mem_regwrite && !bus.mem_memread && bus.mem_rd != 0 && bus.mem_rd == bus.id_rt;
      expectEq({tag, ".pc_write"},     32'(bus.pc_write),     32'(!stall));
      expectEq({tag, ".ifid_write"},   32'(bus.ifid_write),   32'(!stall));
      expectEq({tag, ".idex_bubble"},  32'(bus.idex_bubble),  32'(stall));
      expectEq({tag, ".branch_taken"}, 32'(bus.branch_taken), 32'(tk));
      expectEq({tag, ".ifid_flush"},   32'(bus.ifid_flush),   32'(tk));
      expectEq({tag, ".fwd_a"},        32'(bus.fwd_a),        32'(fa));
      expectEq({tag, ".fwd_b"},        32'(bus.fwd_b),        32'(fb));
      expectEq({tag, ".branch_err"},   32'(bus.branch_err),   32'(mdlErr));
      expectEq({tag, ".taken_cnt"},    32'(bus.taken_cnt),    32'(mdlTaken));
      expectEq({tag, ".stall_cnt"},    32'(bus.stall_cnt),    32'(mdlStall));
      pendStartN = (mdlActive == 0 && br) ? n : 0;
      pendStall  = stall;
      pendTaken  = tk;
      pendBoth   = bus.id_branch && bus.id_branch_not;
   endtask

   task automatic advanceModel();
      @(posedge clk);
      if (mdlActive == 0) begin
         if (pendStartN > 0) begin
            mdlActive    = 1;
            mdlRemaining = pendStartN - 1;
         end
      end else if (mdlRemaining > 0) begin
         mdlRemaining--;
      end else begin
         mdlActive = 0;
      end
      if (pendStall && mdlStall < SAT) mdlStall++;
      if (pendTaken && mdlTaken < SAT) mdlTaken++;
      if (pendBoth) mdlErr = 1;
   endtask

   task automatic step(input string tag, input logic b, input logic bn, input logic z, input int rs, input int rt,
                       input logic exRw, input logic exMr, input int exRd,
                       input logic memRw, input logic memMr, input int memRd);
      applyStimulus(b, bn, z, rs, rt, exRw, exMr, exRd, memRw, memMr, memRd);
      checkOutput(tag);
      advanceModel();
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      clearInputs();
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      clearInputs();
      resetModel();
      repeat (2) @(negedge clk);
      #1;
      expectEq("reset.pc_write",    32'(bus.pc_write),    32'd1);
      expectEq("reset.idex_bubble", 32'(bus.idex_bubble), 32'd0);
      expectEq("reset.taken_cnt",   32'(bus.taken_cnt),   32'd0);
      expectEq("reset.stall_cnt",   32'(bus.stall_cnt),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      step("idle", 0, 0, 0, 3, 4, 0, 0, 0, 0, 0, 0);
      step("beq_nohaz", 1, 0, 1, 8, 9, 0, 0, 0, 0, 0, 0);
      #1;
      expectEq("beq_nohaz.taken_cnt", 32'(bus.taken_cnt), 32'd1);
      expectEq("beq_nohaz.stall_cnt", 32'(bus.stall_cnt), 32'd0);

      for (int i = 0; i < 3; i++) step("lw_beq", 1, 0, 0, 8, 9, 1, 1, 8, 0, 0, 0);
      #1;
      expectEq("lw_beq.stall_cnt", 32'(bus.stall_cnt), 32'd2);

      step("add_bne_stall", 0, 1, 0, 8, 0, 1, 0, 8, 0, 0, 0);
      step("add_bne_fwd",   0, 1, 0, 8, 0, 0, 0, 0, 1, 0, 8);
      #1;
      expectEq("add_bne.taken_cnt", 32'(bus.taken_cnt), 32'd2);

      step("both_high", 1, 1, 1, 2, 3, 0, 0, 0, 0, 0, 0);
      step("both_drop", 0, 0, 0, 2, 3, 0, 0, 0, 0, 0, 0);
      #1;
      expectEq("both.branch_err", 32'(bus.branch_err), 32'd1);
      expectEq("both.taken_cnt",  32'(bus.taken_cnt),  32'd2);

      step("lw_pre_rst", 1, 0, 1, 8, 9, 1, 1, 8, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      expectEq("rst_mid.pc_write",    32'(bus.pc_write),    32'd1);
      expectEq("rst_mid.ifid_write",  32'(bus.ifid_write),  32'd1);
      expectEq("rst_mid.idex_bubble", 32'(bus.idex_bubble), 32'd0);
      expectEq("rst_mid.branch_err",  32'(bus.branch_err),  32'd0);
      expectEq("rst_mid.stall_cnt",   32'(bus.stall_cnt),   32'd0);
      clearInputs();
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_beq", 1, 0, 1, 8, 9, 0, 0, 0, 0, 0, 0);

      step("zero_reg", 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0);
      #1;
      expectEq("zero_reg.stall_cnt", 32'(bus.stall_cnt), 32'd0);

      for (int i = 0; i < 400; i++) begin
         step("rand",
              logic'($urandom_range(0, 9) < 4), logic'($urandom_range(0, 9) < 3), logic'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      doReset();
      for (int i = 0; i < SAT + 10; i++) step("sat_taken", 1, 0, 1, 4, 5, 0, 0, 0, 0, 0, 0);
      #1;
      expectEq("sat.taken_cnt", 32'(bus.taken_cnt), 32'(SAT));
      for (int i = 0; i < 3 * 140; i++) step("sat_stall", 1, 0, 0, 4, 5, 1, 1, 4, 0, 0, 0);
      #1;
      expectEq("sat.stall_cnt", 32'(bus.stall_cnt), 32'(SAT));
      expectEq("sat.taken_hold", 32'(bus.taken_cnt), 32'(SAT));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
